pipeline_stall_ctrl: RTL and testbench

- Consumer side of hazard detection. Takes the data_hazard and control_hazard indications from decode, plus branch resolution from execute.
- Drives the pipeline-register and PC enables: freeze fetch/decode, inject ID/EX bubbles, flush IF/ID on control flow.
- Sits between the decode stage and the PC, IF/ID and ID/EX register instances. Includes a watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline freeze/bubble/flush controller with watchdog and stall counter
//
// Turns the decode-stage hazard flags and execute-stage branch resolution
// into enables for the PC, IF/ID and ID/EX registers. Outputs are Mealy so a
// stall takes effect in the same cycle the hazard is seen.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   data_hazard     RAW hazard on the instruction in ID
//   control_hazard  instruction in ID is a branch/jump
//   branch_resolved branch/jump outcome known in EX this cycle
//   halt            HALT decoded in ID
//   pc_write_en     PC register write enable
//   ifid_write_en   IF/ID register write enable
//   ifid_flush      load NOP into IF/ID
//   idex_bubble     load NOP into ID/EX
//   stall_timeout   one-cycle pulse on watchdog release
//   halted          core halted
//   stall_cycles    saturating count of cycles with pc_write_en low

module pipeline_stall_ctrl #(
    parameter int MAX_STALL      = 3,
    parameter int BRANCH_RESOLVE = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_hazard,
    input  logic                 control_hazard,
    input  logic                 branch_resolved,
    input  logic                 halt,
    output logic                 pc_write_en,
    output logic                 ifid_write_en,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 stall_timeout,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int LIMIT = (MAX_STALL > BRANCH_RESOLVE) ? MAX_STALL : BRANCH_RESOLVE;
    localparam int CW    = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    localparam logic [CW-1:0] MAX_STALL_C = CW'(MAX_STALL);
    localparam logic [CW-1:0] BRANCH_C    = CW'(BRANCH_RESOLVE);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DSTALL,
        CWAIT,
        HALTED
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          use_idle_rules;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        stall_timeout  = 1'b0;
        halted         = 1'b0;
        use_idle_rules = 1'b0;

        case (state)
            IDLE: use_idle_rules = 1'b1;

            DSTALL: begin
                if (!data_hazard) begin
                    // Hazard cleared: the instruction now in ID is judged
                    // afresh, so a branch here goes straight to CWAIT.
                    use_idle_rules = 1'b1;
                end else if (cnt < MAX_STALL_C) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                    cnt_nxt       = cnt + 1'b1;
                end else begin
                    stall_timeout = 1'b1;
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                end
            end

            CWAIT: begin
                // The fetch behind the branch is always discarded.
                ifid_flush = 1'b1;
                if (branch_resolved) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt < BRANCH_C) begin
                    pc_write_en = 1'b0;
                    cnt_nxt     = cnt + 1'b1;
                end else begin
                    stall_timeout = 1'b1;
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                end
            end

            HALTED: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
                halted        = 1'b1;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (use_idle_rules) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (data_hazard) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
                state_nxt     = DSTALL;
                cnt_nxt       = CNT_ONE;
            end else if (control_hazard) begin
                // Branch advances into EX; a bubble follows it in IF/ID.
                pc_write_en = 1'b0;
                ifid_flush  = 1'b1;
                state_nxt   = CWAIT;
                cnt_nxt     = CNT_ONE;
            end else if (halt) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                state_nxt     = HALTED;
            end
        end

        // Outputs take their safe values as soon as reset is asserted.
        if (!rst) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            stall_timeout = 1'b0;
            halted        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write_en && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - self-checking bench for pipeline_stall_ctrl

module tb_pipeline_stall_ctrl;

    localparam int MAX_STALL      = 3;
    localparam int BRANCH_RESOLVE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dh  = 1'b0;
    logic ch  = 1'b0;
    logic br  = 1'b0;
    logic hl  = 1'b0;

    logic        pc, we, fl, bub, tmo, hlt;
    logic [15:0] sc;
    logic        pc4, we4, fl4, bub4, tmo4, hlt4;
    logic [3:0]  sc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MAX_STALL(MAX_STALL), .BRANCH_RESOLVE(BRANCH_RESOLVE), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .data_hazard(dh), .control_hazard(ch),
        .branch_resolved(br), .halt(hl), .pc_write_en(pc), .ifid_write_en(we),
        .ifid_flush(fl), .idex_bubble(bub), .stall_timeout(tmo), .halted(hlt),
        .stall_cycles(sc)
    );

    pipeline_stall_ctrl #(
        .MAX_STALL(MAX_STALL), .BRANCH_RESOLVE(BRANCH_RESOLVE), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .data_hazard(dh), .control_hazard(ch),
        .branch_resolved(br), .halt(hl), .pc_write_en(pc4), .ifid_write_en(we4),
        .ifid_flush(fl4), .idex_bubble(bub4), .stall_timeout(tmo4), .halted(hlt4),
        .stall_cycles(sc4)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b required %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Model: how long the current data stall has run, how old the pending
    // branch is, whether we are halted, and the total frozen-PC cycles.
    typedef struct packed {
        logic pc, we, fl, bub, tmo, hlt;
        int   run;
        int   age;
        logic h;
    } exp_t;

    int   m_run    = 0;
    int   m_age    = 0;
    logic m_halt   = 1'b0;
    int   m_stalls = 0;
    exp_t e;

    function automatic exp_t predict(input int run, input int age, input logic h,
                                     input logic d, input logic c, input logic b,
                                     input logic hh);
        exp_t r;
        r.pc = 1'b1; r.we = 1'b1; r.fl = 1'b0; r.bub = 1'b0;
        r.tmo = 1'b0; r.hlt = 1'b0; r.run = 0; r.age = 0; r.h = h;
        if (h) begin
            r.pc = 1'b0; r.we = 1'b0; r.bub = 1'b1; r.hlt = 1'b1;
        end else if (age > 0) begin
            r.fl = 1'b1;
            if (!b && age < BRANCH_RESOLVE) begin
                r.pc = 1'b0; r.age = age + 1;
            end else if (!b) begin
                r.tmo = 1'b1;
            end
        end else if (d && run == MAX_STALL) begin
            r.tmo = 1'b1;
        end else if (d) begin
            r.pc = 1'b0; r.we = 1'b0; r.bub = 1'b1; r.run = run + 1;
        end else if (c) begin
            r.pc = 1'b0; r.fl = 1'b1; r.age = 1;
        end else if (hh) begin
            r.pc = 1'b0; r.we = 1'b0; r.h = 1'b1;
        end
        return r;
    endfunction

    always_comb e = predict(m_run, m_age, m_halt, dh, ch, br, hl);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run    <= 0;
            m_age    <= 0;
            m_halt   <= 1'b0;
            m_stalls <= 0;
        end else begin
            m_run  <= e.run;
            m_age  <= e.age;
            m_halt <= e.h;
            if (!e.pc) m_stalls <= m_stalls + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk1("rst_pc_write_en", pc, 1'b0);
            chk1("rst_ifid_write_en", we, 1'b0);
            chk1("rst_ifid_flush", fl, 1'b1);
            chk1("rst_idex_bubble", bub, 1'b1);
            chk1("rst_stall_timeout", tmo, 1'b0);
            chk1("rst_halted", hlt, 1'b0);
            chkn("rst_stall_cycles", int'(sc), 0);
        end else begin
            chk1("pc_write_en", pc, e.pc);
            chk1("ifid_write_en", we, e.we);
            chk1("ifid_flush", fl, e.fl);
            chk1("idex_bubble", bub, e.bub);
            chk1("stall_timeout", tmo, e.tmo);
            chk1("halted", hlt, e.hlt);
            chkn("stall_cycles", int'(sc), sat(m_stalls, 65535));
            chk1("pc_write_en_w4", pc4, e.pc);
            chk1("stall_timeout_w4", tmo4, e.tmo);
            chkn("stall_cycles_w4", int'(sc4), sat(m_stalls, 15));
        end
    end

    task automatic drive(input logic d, input logic c, input logic b, input logic h);
        @(posedge clk);
        #1;
        dh = d; ch = c; br = b; hl = h;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk1("lit_reset_pc", pc, 1'b0);
        chk1("lit_reset_flush", fl, 1'b1);
        chk1("lit_reset_bubble", bub, 1'b1);
        chkn("lit_reset_cycles", int'(sc), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Idle pipeline
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk1("lit_idle_pc", pc, 1'b1);
        chk1("lit_idle_we", we, 1'b1);
        chk1("lit_idle_flush", fl, 1'b0);
        chk1("lit_idle_bubble", bub, 1'b0);
        chkn("lit_idle_cycles", int'(sc), 0);

        // Short data stall
        drive(1'b1, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_ds1_bubble", bub, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_ds2_pc", pc, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_ds_release_pc", pc, 1'b1);
        chk1("lit_ds_release_tmo", tmo, 1'b0);
        chkn("lit_ds_cycles", int'(sc), 2);

        // Watchdog release on a long data stall
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0); settle();
            if (i == 4) begin
                chk1("lit_wd_tmo", tmo, 1'b1);
                chk1("lit_wd_pc", pc, 1'b1);
            end
            if (i == 5) chk1("lit_wd_restall_pc", pc, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Branch resolved in its second cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0); settle();
        chk1("lit_br1_flush", fl, 1'b1);
        chk1("lit_br1_pc", pc, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0); settle();
        chk1("lit_br2_flush", fl, 1'b1);
        chk1("lit_br2_pc", pc, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_br3_flush", fl, 1'b0);

        // Branch never resolved
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_bt_wait_tmo", tmo, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_bt_tmo", tmo, 1'b1);
        chk1("lit_bt_pc", pc, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chkn("lit_bt_cycles", int'(sc), 10);

        // Data over control, then the branch
        drive(1'b1, 1'b1, 1'b0, 1'b0); settle();
        chk1("lit_pri_bubble", bub, 1'b1);
        chk1("lit_pri_flush", fl, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0); settle();
        chk1("lit_pri_cw_flush", fl, 1'b1);
        chk1("lit_pri_cw_bubble", bub, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Hazards ignored while waiting on a branch
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0); settle();
        chk1("lit_cw_ign_bubble", bub, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chkn("lit_pre_halt_cycles", int'(sc), 14);

        // Halt and counter saturation
        drive(1'b0, 1'b0, 1'b0, 1'b1); settle();
        chk1("lit_halt_entry_halted", hlt, 1'b0);
        chk1("lit_halt_entry_we", we, 1'b0);
        for (int i = 0; i < 21; i++) drive(i == 5, i == 5, i == 5, 1'b0);
        settle();
        chk1("lit_halted", hlt, 1'b1);
        chkn("lit_halt_cycles", int'(sc), 35);
        chkn("lit_halt_cycles_w4", int'(sc4), 15);
        rst = 1'b0;
        #1;
        chk1("lit_halt_rst_halted", hlt, 1'b0);
        chkn("lit_halt_rst_cycles", int'(sc), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_post_halt_pc", pc, 1'b1);

        // Reset in the cycle a branch watchdog would fire
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_pre_rst_tmo", tmo, 1'b1);
        rst = 1'b0;
        #1;
        chk1("lit_rst_cw_tmo", tmo, 1'b0);
        chk1("lit_rst_cw_pc", pc, 1'b0);
        chk1("lit_rst_cw_bubble", bub, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0); settle();
        chk1("lit_after_rst_tmo", tmo, 1'b0);
        chk1("lit_after_rst_flush", fl, 1'b0);
        chk1("lit_after_rst_pc", pc, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
